// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU operation sequencer, the ALU and the future decoder.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } seq_state_t;

  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h06;
  localparam logic [7:0] OP_AND = 8'h07;
  localparam logic [7:0] OP_OR  = 8'h08;
  localparam logic [7:0] OP_XOR = 8'h09;

endpackage

// File: rtl/alu_op_sequencer.sv
// Runs one ALU command at a time: read two RAM words, present them to the ALU,
// write the result back and keep the carry for multi-word arithmetic chains.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4,
  parameter int OPW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPW-1:0]    cmd_op,
  input  logic [AWIDTH-1:0] cmd_a_addr,
  input  logic [AWIDTH-1:0] cmd_b_addr,
  input  logic [AWIDTH-1:0] cmd_c_addr,
  input  logic              cmd_use_cy,
  input  logic              cmd_no_wb,
  output logic [AWIDTH-1:0] ram_a_addr,
  input  logic [WIDTH-1:0]  ram_a_data,
  output logic [AWIDTH-1:0] ram_b_addr,
  input  logic [WIDTH-1:0]  ram_b_data,
  output logic [AWIDTH-1:0] ram_c_addr,
  output logic [WIDTH-1:0]  ram_c_data,
  output logic              ram_c_we,
  output logic [OPW-1:0]    alu_op_code,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_c_in,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_c_out,
  output logic              carry_flag,
  output logic              busy,
  output logic              done
);

  seq_state_t state, next_state;

  logic [OPW-1:0]    op_q;
  logic [AWIDTH-1:0] a_addr_q, b_addr_q, c_addr_q;
  logic              use_cy_q, no_wb_q;
  logic [WIDTH-1:0]  alu_a_q, alu_b_q;
  logic              carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Command fields are frozen at accept; operands land one cycle after the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      use_cy_q <= 1'b0;
      no_wb_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        a_addr_q <= cmd_a_addr;
        b_addr_q <= cmd_b_addr;
        c_addr_q <= cmd_c_addr;
        use_cy_q <= cmd_use_cy;
        no_wb_q  <= cmd_no_wb;
      end
      if (state == EXEC) begin
        alu_a_q <= ram_a_data;
        alu_b_q <= ram_b_data;
      end
      if (state == WB) carry_q <= alu_c_out;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    ram_a_addr = '0;
    ram_b_addr = '0;
    ram_c_addr = '0;
    ram_c_data = '0;
    ram_c_we   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = FETCH;
      end
      FETCH: begin
        ram_a_addr = a_addr_q;
        ram_b_addr = b_addr_q;
        next_state = EXEC;
      end
      EXEC: begin
        ram_a_addr = a_addr_q;
        ram_b_addr = b_addr_q;
        next_state = WB;
      end
      WB: begin
        done       = 1'b1;
        ram_c_we   = ~no_wb_q;
        if (!no_wb_q) begin
          ram_c_addr = c_addr_q;
          ram_c_data = alu_result;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy        = ~cmd_ready;
  assign alu_op_code = op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_c_in    = use_cy_q & carry_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural RAM/ALU around the DUT, a command-level
// reference model checked every cycle, plus directed literal scenarios and random traffic.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_op;
  logic [3:0] cmd_a_addr, cmd_b_addr, cmd_c_addr;
  logic       cmd_use_cy, cmd_no_wb;
  logic [3:0] ram_a_addr, ram_b_addr, ram_c_addr;
  logic [7:0] ram_a_data, ram_b_data, ram_c_data;
  logic       ram_c_we;
  logic [7:0] alu_op_code, alu_a, alu_b, alu_result;
  logic       alu_c_in, alu_c_out;
  logic       carry_flag, busy, done;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .AWIDTH(4), .OPW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
    .cmd_use_cy(cmd_use_cy), .cmd_no_wb(cmd_no_wb),
    .ram_a_addr(ram_a_addr), .ram_a_data(ram_a_data),
    .ram_b_addr(ram_b_addr), .ram_b_data(ram_b_data),
    .ram_c_addr(ram_c_addr), .ram_c_data(ram_c_data), .ram_c_we(ram_c_we),
    .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out),
    .carry_flag(carry_flag), .busy(busy), .done(done)
  );

  // ALU behaviour: bit 8 is carry-out (add) or borrow (sub)
  function automatic logic [8:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      OP_SUB:  return {1'b0, a} - {1'b0, b} - {8'd0, cin};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_c_out, alu_result} = alu_fn(alu_op_code, alu_a, alu_b, alu_c_in);

  // Word RAM: registered reads on A/B, write on C, plus a bench preload port
  logic [7:0] mem [16];
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    ram_a_data <= mem[ram_a_addr];
    ram_b_data <= mem[ram_b_addr];
    if (ram_c_we) mem[ram_c_addr] <= ram_c_data;
    if (pre_we)   mem[pre_addr]   <= pre_data;
  end

  // Command-level reference: result computed at accept, retired three edges later
  logic [7:0] m_mem [16];
  bit         m_busy = 0;
  int         m_age = 0;
  logic       m_carry = 1'b0;
  logic [7:0] m_res, m_op;
  logic       m_cout, m_nowb, m_usecy;
  logic [3:0] m_a, m_b, m_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 0;
      m_age   = 0;
      m_carry = 1'b0;
    end else begin
      if (pre_we) m_mem[pre_addr] = pre_data;
      if (m_busy) begin
        m_age++;
        if (m_age == 3) begin
          if (!m_nowb) m_mem[m_c] = m_res;
          m_carry = m_cout;
          m_busy  = 0;
        end
      end else if (cmd_valid) begin
        m_busy  = 1;
        m_age   = 0;
        m_op    = cmd_op;
        m_a     = cmd_a_addr;
        m_b     = cmd_b_addr;
        m_c     = cmd_c_addr;
        m_nowb  = cmd_no_wb;
        m_usecy = cmd_use_cy;
        {m_cout, m_res} = alu_fn(cmd_op, m_mem[cmd_a_addr], m_mem[cmd_b_addr],
                                 cmd_use_cy & m_carry);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      logic exp_wb, exp_we;
      exp_wb = m_busy && (m_age == 2);
      exp_we = exp_wb && !m_nowb;
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("done", 32'(done), 32'(exp_wb));
      checkOutput("ram_c_we", 32'(ram_c_we), 32'(exp_we));
      checkOutput("ram_c_addr", 32'(ram_c_addr), exp_we ? 32'(m_c) : 32'd0);
      checkOutput("ram_c_data", 32'(ram_c_data), exp_we ? 32'(m_res) : 32'd0);
      checkOutput("carry_flag", 32'(carry_flag), 32'(m_carry));
      checkOutput("ram_a_addr", 32'(ram_a_addr), (m_busy && m_age < 2) ? 32'(m_a) : 32'd0);
      checkOutput("ram_b_addr", 32'(ram_b_addr), (m_busy && m_age < 2) ? 32'(m_b) : 32'd0);
      if (exp_wb) begin
        checkOutput("alu_c_in", 32'(alu_c_in), 32'(m_usecy & m_carry));
        checkOutput("alu_op_code", 32'(alu_op_code), 32'(m_op));
      end
    end
  end

  task automatic setMem(input logic [3:0] addr, input logic [7:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Offers a command and returns on the negedge after it was accepted (FETCH cycle)
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic use_cy, input logic no_wb);
    int n = 0;
    cmd_op     = op;
    cmd_a_addr = a;
    cmd_b_addr = b;
    cmd_c_addr = c;
    cmd_use_cy = use_cy;
    cmd_no_wb  = no_wb;
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] ops [6];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND;
    ops[3] = OP_OR;  ops[4] = OP_XOR; ops[5] = 8'hEE;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a_addr = '0; cmd_b_addr = '0; cmd_c_addr = '0;
    cmd_use_cy = 1'b0; cmd_no_wb = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(ram_c_we), 32'd0);
    checkOutput("rst_carry", 32'(carry_flag), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) setMem(4'(i), 8'h00);
    cmp_en = 1;

    $display("[TB] directed ADD with latency");
    setMem(4'd1, 8'h12);
    setMem(4'd2, 8'h34);
    applyStimulus(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    checkOutput("add_fetch_done", 32'(done), 32'd0);
    checkOutput("add_fetch_addr", 32'(ram_a_addr), 32'd1);
    @(negedge clk);
    checkOutput("add_exec_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("add_wb_done", 32'(done), 32'd1);
    checkOutput("add_wb_we", 32'(ram_c_we), 32'd1);
    checkOutput("add_wb_data", 32'(ram_c_data), 32'h46);
    waitIdle();
    checkOutput("add_mem3", 32'(mem[3]), 32'h46);
    checkOutput("add_carry", 32'(carry_flag), 32'd0);

    $display("[TB] directed carry chain");
    setMem(4'd0, 8'hFF);
    setMem(4'd1, 8'h01);
    applyStimulus(OP_ADD, 4'd0, 4'd1, 4'd4, 1'b0, 1'b0);
    waitIdle();
    checkOutput("chain_mem4", 32'(mem[4]), 32'h00);
    checkOutput("chain_carry1", 32'(carry_flag), 32'd1);
    setMem(4'd2, 8'h00);
    setMem(4'd3, 8'h00);
    applyStimulus(OP_ADD, 4'd2, 4'd3, 4'd5, 1'b1, 1'b0);
    waitIdle();
    checkOutput("chain_mem5", 32'(mem[5]), 32'h01);
    checkOutput("chain_carry0", 32'(carry_flag), 32'd0);

    $display("[TB] directed in-place dependency");
    setMem(4'd6, 8'h10);
    setMem(4'd7, 8'h01);
    applyStimulus(OP_ADD, 4'd6, 4'd7, 4'd6, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 4'd6, 4'd7, 4'd6, 1'b0, 1'b0);
    checkOutput("dep_mem6_first", 32'(mem[6]), 32'h11);
    waitIdle();
    checkOutput("dep_mem6_second", 32'(mem[6]), 32'h12);

    $display("[TB] directed busy hold");
    setMem(4'd9, 8'h22);
    setMem(4'd10, 8'h11);
    applyStimulus(OP_ADD, 4'd9, 4'd10, 4'd11, 1'b0, 1'b0);
    repeat (3) begin
      cmd_op = 8'($urandom); cmd_a_addr = 4'($urandom); cmd_b_addr = 4'($urandom);
      cmd_c_addr = 4'($urandom); cmd_use_cy = 1'($urandom); cmd_no_wb = 1'($urandom);
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    applyStimulus(OP_XOR, 4'd9, 4'd10, 4'd12, 1'b0, 1'b0);
    checkOutput("busy_mem11", 32'(mem[11]), 32'h33);
    waitIdle();
    checkOutput("busy_mem12", 32'(mem[12]), 32'h33);

    $display("[TB] directed compare-only");
    setMem(4'd13, 8'hF0);
    setMem(4'd14, 8'h20);
    setMem(4'd8, 8'h5A);
    applyStimulus(OP_ADD, 4'd13, 4'd14, 4'd8, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("nowb_done", 32'(done), 32'd1);
    checkOutput("nowb_we", 32'(ram_c_we), 32'd0);
    waitIdle();
    checkOutput("nowb_mem8", 32'(mem[8]), 32'h5A);
    checkOutput("nowb_carry", 32'(carry_flag), 32'd1);

    $display("[TB] directed reset during write-back");
    setMem(4'd15, 8'h77);
    applyStimulus(OP_ADD, 4'd13, 4'd14, 4'd15, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rstwb_done_before", 32'(done), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstwb_we_now", 32'(ram_c_we), 32'd0);
    @(negedge clk);
    checkOutput("rstwb_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rstwb_we", 32'(ram_c_we), 32'd0);
    checkOutput("rstwb_done", 32'(done), 32'd0);
    checkOutput("rstwb_carry", 32'(carry_flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstwb_mem15", 32'(mem[15]), 32'h77);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) setMem(4'(i), 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      applyStimulus(ops[$urandom_range(0, 5)], 4'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 4)) begin
        cmd_op = ops[$urandom_range(0, 5)]; cmd_a_addr = 4'($urandom);
        cmd_b_addr = 4'($urandom); cmd_c_addr = 4'($urandom);
        cmd_use_cy = 1'($urandom); cmd_no_wb = 1'($urandom);
        cmd_valid = 1'($urandom);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      if (i == 30) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    waitIdle();
    for (int i = 0; i < 16; i++) checkOutput("final_mem", 32'(mem[i]), 32'(m_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
